// File: rtl/chacha20_keystream_controller.sv
// ChaCha20 keystream sequencer: builds the block state, drives one iterated core,
// applies the feed-forward and hands out one 512-bit keystream block per handshake.
module chacha20_keystream_controller #(
    parameter bit ALLOW_COUNTER_WRAP = 1'b0
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         cfg_load,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  initial_counter,
    input  logic         stream_start,
    input  logic [15:0]  block_count,
    output logic         core_start,
    output logic [511:0] core_input,
    input  logic         core_finished,
    input  logic [511:0] core_output,
    output logic [511:0] keystream,
    output logic         keystream_valid,
    input  logic         keystream_ready,
    output logic         busy,
    output logic         done,
    output logic         wrap_error
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = 16;
    localparam int unsigned STATE_W = 512;
    localparam int unsigned KEY_W   = 256;
    localparam int unsigned NONCE_W = 96;
    localparam int unsigned CNT_W   = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_KICK = 3'd1;
    localparam logic [2:0] ST_ARM  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_EMIT = 3'd4;

    logic [2:0]         state_q,       state_d;
    logic [KEY_W-1:0]   key_q,         key_d;
    logic [NONCE_W-1:0] nonce_q,       nonce_d;
    logic [WORD_W-1:0]  counter_q,     counter_d;
    logic [CNT_W-1:0]   remaining_q,   remaining_d;
    logic               core_start_q,  core_start_d;
    logic [STATE_W-1:0] core_input_q,  core_input_d;
    logic [STATE_W-1:0] keystream_q,   keystream_d;
    logic               valid_q,       valid_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic               wrap_error_q,  wrap_error_d;

    // Initial block state: constants, key, counter, nonce from word 0 upward.
    function automatic logic [STATE_W-1:0] build_state(
        input logic [KEY_W-1:0]   k,
        input logic [NONCE_W-1:0] n,
        input logic [WORD_W-1:0]  c
    );
        return {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    endfunction

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        nonce_d      = nonce_q;
        counter_d    = counter_q;
        remaining_d  = remaining_q;
        core_input_d = core_input_q;
        keystream_d  = keystream_q;
        wrap_error_d = wrap_error_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    key_d        = key;
                    nonce_d      = nonce;
                    counter_d    = initial_counter;
                    wrap_error_d = 1'b0;
                end
                if (stream_start) begin
                    if (block_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = block_count;
                        state_d     = ST_KICK;
                    end
                end
            end
            ST_KICK: state_d = ST_ARM;
            // The idle core still reports finished here, so it is not looked at.
            ST_ARM:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_finished) begin
                    for (int unsigned i = 0; i < N_WORDS; i++) begin
                        keystream_d[WORD_W*i +: WORD_W] = core_output[WORD_W*i +: WORD_W]
                                                        + core_input_q[WORD_W*i +: WORD_W];
                    end
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (keystream_ready) begin
                    counter_d   = counter_q + WORD_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (counter_q == '1 && !ALLOW_COUNTER_WRAP) begin
                        wrap_error_d = 1'b1;
                        done_d       = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_KICK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Core input is captured on entry to KICK and held until the next KICK.
        core_start_d = (state_d == ST_KICK);
        if (state_d == ST_KICK) begin
            core_input_d = build_state(key_d, nonce_d, counter_d);
        end
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            nonce_q      <= '0;
            counter_q    <= '0;
            remaining_q  <= '0;
            core_start_q <= 1'b0;
            core_input_q <= '0;
            keystream_q  <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wrap_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            counter_q    <= counter_d;
            remaining_q  <= remaining_d;
            core_start_q <= core_start_d;
            core_input_q <= core_input_d;
            keystream_q  <= keystream_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wrap_error_q <= wrap_error_d;
        end
    end

    assign core_start      = core_start_q;
    assign core_input      = core_input_q;
    assign keystream       = keystream_q;
    assign keystream_valid = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign wrap_error      = wrap_error_q;

endmodule

// File: tb/tb_chacha20_keystream_controller.sv
// Bench for chacha20_keystream_controller: two instances (wrap disallowed / allowed),
// each with a behavioural core, checked against a block-level ChaCha20 reference.
module tb_chacha20_keystream_controller;

    localparam int RUN_BOUND = 1000;

    logic         clock = 1'b0;
    logic         clear;
    logic         cfg_load;
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  initial_counter;
    logic         stream_start;
    logic [15:0]  block_count;
    logic         keystream_ready;

    logic         core_start_w [2];
    logic [511:0] core_input_w [2];
    logic [511:0] ks           [2];
    logic         ks_valid     [2];
    logic         busy_w       [2];
    logic         done_w       [2];
    logic         wrap_w       [2];

    logic [511:0] acc_ks   [2][$];
    logic [31:0]  kick_ctr [2][$];
    int           done_cnt  [2];
    int           emit_viol [2];

    logic [255:0] key_m;
    logic [95:0]  nonce_m;
    logic [31:0]  ctr_m  [2];
    bit           wrap_m [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
        return (v << r) | (v >> (32 - r));
    endfunction

    function automatic logic [511:0] qr(input logic [511:0] s, input int a, input int b,
                                        input int c, input int d);
        logic [31:0] va, vb, vc, vd;
        va = s[32*a +: 32]; vb = s[32*b +: 32]; vc = s[32*c +: 32]; vd = s[32*d +: 32];
        va = va + vb; vd = rotl(vd ^ va, 16);
        vc = vc + vd; vb = rotl(vb ^ vc, 12);
        va = va + vb; vd = rotl(vd ^ va, 8);
        vc = vc + vd; vb = rotl(vb ^ vc, 7);
        s[32*a +: 32] = va; s[32*b +: 32] = vb; s[32*c +: 32] = vc; s[32*d +: 32] = vd;
        return s;
    endfunction

    function automatic logic [511:0] chacha_rounds(input logic [511:0] s);
        for (int r = 0; r < 10; r++) begin
            s = qr(s, 0, 4, 8, 12);  s = qr(s, 1, 5, 9, 13);
            s = qr(s, 2, 6, 10, 14); s = qr(s, 3, 7, 11, 15);
            s = qr(s, 0, 5, 10, 15); s = qr(s, 1, 6, 11, 12);
            s = qr(s, 2, 7, 8, 13);  s = qr(s, 3, 4, 9, 14);
        end
        return s;
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
        logic [511:0] init, r, o;
        init = {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        r = chacha_rounds(init);
        for (int i = 0; i < 16; i++) o[32*i +: 32] = r[32*i +: 32] + init[32*i +: 32];
        return o;
    endfunction

    // How many blocks a run emits and whether it ends on a counter wrap.
    function automatic void model_run(input logic [31:0] c0, input int n, input bit allow,
                                      output int nb, output bit w);
        nb = 0;
        w  = 1'b0;
        for (int i = 0; i < n; i++) begin
            nb++;
            if (i == n - 1) break;
            if (c0 + 32'(i) == 32'hFFFFFFFF && !allow) begin
                w = 1'b1;
                break;
            end
        end
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [95:0] rand_nonce();
        return {$urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic         core_fin;
        logic [511:0] core_out;
        int           core_cnt;

        chacha20_keystream_controller #(.ALLOW_COUNTER_WRAP(g == 1)) u_dut (
            .clock           (clock),
            .clear           (clear),
            .cfg_load        (cfg_load),
            .key             (key),
            .nonce           (nonce),
            .initial_counter (initial_counter),
            .stream_start    (stream_start),
            .block_count     (block_count),
            .core_start      (core_start_w[g]),
            .core_input      (core_input_w[g]),
            .core_finished   (core_fin),
            .core_output     (core_out),
            .keystream       (ks[g]),
            .keystream_valid (ks_valid[g]),
            .keystream_ready (keystream_ready),
            .busy            (busy_w[g]),
            .done            (done_w[g]),
            .wrap_error      (wrap_w[g])
        );

        // Core: finished drops after start and returns 9 cycles later with the rounds result.
        always @(posedge clock) begin
            if (clear) begin
                core_fin <= 1'b1;
                core_cnt <= 0;
                core_out <= '0;
            end else if (core_start_w[g]) begin
                core_fin <= 1'b0;
                core_cnt <= 9;
                core_out <= chacha_rounds(core_input_w[g]);
            end else if (!core_fin) begin
                if (core_cnt == 1) core_fin <= 1'b1;
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (ks_valid[d] && keystream_ready) acc_ks[d].push_back(ks[d]);
            if (core_start_w[d]) begin
                kick_ctr[d].push_back(core_input_w[d][415:384]);
                if (ks_valid[d]) emit_viol[d]++;
            end
            if (done_w[d]) done_cnt[d]++;
        end
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_cfg(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
        key             = k;
        nonce           = n;
        initial_counter = c;
        cfg_load        = 1'b1;
        step();
        cfg_load = 1'b0;
        key_m    = k;
        nonce_m  = n;
        for (int d = 0; d < 2; d++) begin
            ctr_m[d]  = c;
            wrap_m[d] = 1'b0;
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s_ks%0d", tag, d), ks[d], '0);
            check_eq($sformatf("%s_cin%0d", tag, d), core_input_w[d], '0);
            check_eq($sformatf("%s_cst%0d", tag, d), core_start_w[d], 1'b0);
            check_eq($sformatf("%s_val%0d", tag, d), ks_valid[d], 1'b0);
            check_eq($sformatf("%s_busy%0d", tag, d), busy_w[d], 1'b0);
            check_eq($sformatf("%s_done%0d", tag, d), done_w[d], 1'b0);
            check_eq($sformatf("%s_wrap%0d", tag, d), wrap_w[d], 1'b0);
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            acc_ks[d].delete();
            kick_ctr[d].delete();
            done_cnt[d]  = 0;
            emit_viol[d] = 0;
        end
    endtask

    // One run with random ready; optional early back-pressure hold and busy-time disturbance.
    task automatic run_check(input string tag, input int n, input int hold, input bit disturb);
        logic [511:0] snap;
        logic [31:0]  c;
        int           t, nb;
        bit           w;
        clear_logs();
        block_count     = 16'(n);
        keystream_ready = 1'b0;
        stream_start    = 1'b1;
        step();
        stream_start = 1'b0;
        t = 1;
        if (hold > 0) begin
            while (!ks_valid[0] && t < 200) begin step(); t++; end
            snap = ks[0];
            repeat (hold) begin step(); t++; end
            check_eq({tag, "_hold_stable"}, ks[0], snap);
            check_eq({tag, "_hold_valid"}, ks_valid[0], 1'b1);
        end
        while ((busy_w[0] || busy_w[1]) && t < RUN_BOUND) begin
            keystream_ready = 1'($urandom_range(0, 1));
            if (disturb && (t == 4 || t == 14)) begin
                cfg_load        = 1'b1;
                stream_start    = 1'b1;
                key             = rand_key();
                nonce           = rand_nonce();
                initial_counter = $urandom;
                block_count     = 16'($urandom_range(1, 9));
            end else begin
                cfg_load     = 1'b0;
                stream_start = 1'b0;
            end
            step();
            t++;
        end
        cfg_load        = 1'b0;
        stream_start    = 1'b0;
        keystream_ready = 1'b0;
        check_eq({tag, "_run_idle"}, busy_w[0] | busy_w[1], 1'b0);
        step();
        for (int d = 0; d < 2; d++) begin
            model_run(ctr_m[d], n, d == 1, nb, w);
            wrap_m[d] = wrap_m[d] | w;
            check_eq($sformatf("%s_blocks%0d", tag, d), acc_ks[d].size(), nb);
            check_eq($sformatf("%s_kicks%0d", tag, d), kick_ctr[d].size(), nb);
            for (int i = 0; i < nb; i++) begin
                c = ctr_m[d] + 32'(i);
                if (i < acc_ks[d].size())
                    check_eq($sformatf("%s_ks%0d_%0d", tag, d, i), acc_ks[d][i],
                             ref_block(key_m, nonce_m, c));
                if (i < kick_ctr[d].size())
                    check_eq($sformatf("%s_kctr%0d_%0d", tag, d, i), kick_ctr[d][i], c);
            end
            check_eq($sformatf("%s_done%0d", tag, d), done_cnt[d], 1);
            check_eq($sformatf("%s_wrap%0d", tag, d), wrap_w[d], wrap_m[d]);
            check_eq($sformatf("%s_emitkick%0d", tag, d), emit_viol[d], 0);
            ctr_m[d] = ctr_m[d] + 32'(nb);
        end
    endtask

    initial begin
        int t;
        clear           = 1'b1;
        cfg_load        = 1'b0;
        stream_start    = 1'b0;
        keystream_ready = 1'b0;
        key             = '0;
        nonce           = '0;
        initial_counter = '0;
        block_count     = '0;
        repeat (3) step();
        check_cleared("reset");
        clear = 1'b0;
        step();

        // RFC 8439 block-function vector, config and start in the same cycle.
        for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
        nonce           = {32'h00000000, 32'h4a000000, 32'h09000000};
        initial_counter = 32'd1;
        block_count     = 16'd1;
        keystream_ready = 1'b1;
        cfg_load        = 1'b1;
        stream_start    = 1'b1;
        clear_logs();
        step();
        cfg_load     = 1'b0;
        stream_start = 1'b0;
        t = 1;
        while (!ks_valid[0] && t < 40) begin step(); t++; end
        check_eq("rfc_latency", t, 12);
        check_eq("rfc_word0", ks[0][31:0], 32'he4e7f110);
        check_eq("rfc_word15", ks[0][511:480], 32'h4e3c50a2);
        check_eq("rfc_block", ks[0], ref_block(key, nonce, 32'd1));
        step();
        check_eq("rfc_done", done_w[0], 1'b1);
        check_eq("rfc_busy", busy_w[0], 1'b0);
        step();
        check_eq("rfc_done_pulse", done_w[0], 1'b0);
        keystream_ready = 1'b0;
        key_m   = key;
        nonce_m = nonce;
        for (int d = 0; d < 2; d++) begin ctr_m[d] = 32'd2; wrap_m[d] = 1'b0; end

        // Back-pressure on the first of three blocks.
        load_cfg(rand_key(), rand_nonce(), 32'd1);
        run_check("hold", 3, 20, 1'b0);

        // Counter wrap: instance 0 stops with wrap_error, instance 1 keeps going.
        load_cfg(rand_key(), rand_nonce(), 32'hFFFFFFFE);
        run_check("wrap", 4, 0, 1'b0);

        // Zero-length run.
        clear_logs();
        block_count  = 16'd0;
        stream_start = 1'b1;
        step();
        stream_start = 1'b0;
        check_eq("zero_done", done_w[0], 1'b1);
        check_eq("zero_busy", busy_w[0], 1'b0);
        step();
        check_eq("zero_done_pulse", done_w[0], 1'b0);
        check_eq("zero_busy2", busy_w[0], 1'b0);
        check_eq("zero_kicks", kick_ctr[0].size(), 0);

        // Config and start pulses while busy are ignored; follow-up run continues the counter.
        load_cfg(rand_key(), rand_nonce(), $urandom);
        run_check("disturb", 2, 0, 1'b1);
        run_check("cont", 1, 0, 1'b0);

        // Clear in the middle of WAIT.
        load_cfg(rand_key(), rand_nonce(), $urandom);
        block_count     = 16'd2;
        keystream_ready = 1'b1;
        stream_start    = 1'b1;
        step();
        stream_start = 1'b0;
        repeat (4) step();
        clear = 1'b1;
        step();
        check_cleared("midclear");
        clear = 1'b0;
        keystream_ready = 1'b0;
        step();
        load_cfg(rand_key(), rand_nonce(), $urandom);
        run_check("postclear", 3, 0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            load_cfg(rand_key(), rand_nonce(), $urandom);
            run_check($sformatf("rand%0d", r), $urandom_range(1, 4), 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
